regfile_dump: RTL and testbench
===============================

# regfile_dump

Debug read-out engine for the 8×8-bit register file. On a start request it freezes the core, walks r0..r7 through one register-file read port, and streams a framed snapshot on a byte-wide valid/ready interface toward the debug link. Frame: header byte, 8 register bytes in index order, then a checksum byte. It sits beside the register file, driving a read-address port and sampling that port's data. It has no write path.

## Interface
Parameters:
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  dump request; sampled only in IDLE.
- stall  out  1  core freeze; high while busy, holds register-file contents stable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the checksum byte is accepted.
- rd_addr  out  3  register-file read address (combinational read port).
- rd_data  in  8  register-file read data for rd_addr.
- tx_data  out  8  stream byte; registered.
- tx_valid  out  1  stream byte valid; registered.
- tx_ready  in  1  sink accepts the byte when tx_valid and tx_ready are both high at a rising edge.

## Operation
- Reset values: state IDLE, ptr=0, csum=0, stall=0, busy=0, done=0, tx_valid=0, tx_data=0, rd_addr=0.
- rd_addr = ptr[2:0]. ptr is a 4-bit value in the range 0..8. When ptr=8, rd_addr=0 and the read data is ignored.
- IDLE: tx_valid=0. If start=1, go to SETTLE and set ptr=0 and csum=0.
- SETTLE: one cycle with stall=1 and tx_valid=0, so any write in flight completes. Next state is HDR, with tx_data=HEADER and tx_valid=1.
- HDR: on accept, tx_data<=rd_data (r0), csum<=csum+rd_data, ptr<=1, and go to DATA.
- DATA: on accept, if ptr<8 then tx_data<=rd_data, csum<=csum+rd_data, and ptr<=ptr+1. If ptr==8 then tx_data<=csum and go to CSUM.
- CSUM: on accept, tx_valid<=0 and go to IDLE. Pulse done=1 for the following cycle.
- Checksum is the sum of the 8 register bytes modulo 256. The header is excluded. Overflow wraps silently.
- stall and busy are decoded from the state: high in SETTLE, HDR, DATA and CSUM.

## Timing
- Backpressure: while tx_valid=1 and tx_ready=0, tx_data, tx_valid, ptr and csum hold.
- tx_valid never drops without a handshake.
- tx_ready while tx_valid=0 has no effect.
- Latency with tx_ready tied high:
  - start sampled at edge 0.
  - SETTLE in cycle 1.
  - Header valid from edge 1.
  - Ten beats accepted at edges 2..11.
  - done=1 and busy=0 in the cycle after edge 11.
  - A frame costs 12 cycles minimum.
- start while busy is ignored and not queued.
- start held high continuously: the next frame begins one cycle after done, because IDLE samples start and done is high in that same cycle.
- reset_n low mid-frame: all outputs return to reset values immediately. The frame is aborted with no done and no checksum byte, and stall releases asynchronously.
- Register data is sampled at the accepting edge of the previous beat. Any write landing while stall=1 is a core violation and outside the block's control.

## Test plan
- r0..r7 = 01..08, tx_ready=1, start pulse -> stream A5,01,02,03,04,05,06,07,08,24. done pulses exactly once, 12 cycles after start. stall is high for cycles 1..11.
- All registers FF -> stream A5, eight bytes FF, then F8 (checksum wrap). tx_valid stays continuous from edge 1 to edge 11.
- Same data as the first scenario with tx_ready toggling 1,0,0,1 repeating -> identical byte sequence. tx_data and tx_valid are stable in every stalled cycle, and each byte is accepted exactly once.
- start pulsed again during DATA -> ignored: single frame and single done. A start in the done cycle -> second frame A5.. begins with SETTLE in the next cycle.
- reset_n asserted after the third accepted beat -> stall, busy, tx_valid and done go to 0 at once, with no CSUM byte and no done. A new start then produces a complete frame with the correct checksum.
- r3 changed by the bench while stall=0 before start, then held -> the frame reflects the new r3 value and the checksum matches it.

Source files
------------

// File: rtl/regfile_dump.sv
// Purpose : debug read-out engine; freezes the core and streams a framed snapshot of r0..r7.
// Latency : start sampled at edge 0, header valid from edge 1, ten beats at edges 2..11 minimum, done the cycle after.
// Backpr. : tx_data/tx_valid/ptr/csum hold while tx_valid=1 and tx_ready=0; tx_valid only drops after a handshake.
//
// Ports:
//   clk       - system clock, all state on rising edge
//   reset_n   - asynchronous active-low reset
//   start     - dump request, sampled only in IDLE
//   stall     - core freeze, high whenever the engine is busy
//   busy      - high in any state other than IDLE
//   done      - one-cycle pulse after the checksum byte is accepted
//   rd_addr   - register-file read address (combinational read port)
//   rd_data   - register-file read data for rd_addr
//   tx_data   - stream byte (registered)
//   tx_valid  - stream byte valid (registered)
//   tx_ready  - sink ready; a beat transfers when tx_valid and tx_ready are high at a rising edge
//
// Frame: HEADER, r0..r7 in index order, then sum of r0..r7 modulo 256.

module regfile_dump #(
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       stall,
    output logic       busy,
    output logic       done,
    output logic [2:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_HDR    = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [3:0] r_ptr;       // next register to read, 0..8; 8 means all eight fetched
    logic [7:0] r_csum;      // running sum of the register bytes fetched so far
    logic [7:0] r_tx_data;
    logic       r_tx_valid;
    logic       r_done;

    logic       w_accept;    // current beat leaves this cycle
    logic       w_ptr_end;   // every register byte has already been loaded into tx_data

    assign w_accept  = r_tx_valid & tx_ready;
    assign w_ptr_end = r_ptr[3];

    // Read address follows the pointer directly; at ptr=8 it wraps to 0 and
    // the returned data is not used.
    assign rd_addr = r_ptr[2:0];

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign done     = r_done;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            // Single freeze cycle so a register write already in flight lands
            // before r0 is fetched.
            ST_SETTLE: begin
                w_state_nxt = ST_HDR;
            end
            ST_HDR: begin
                if (w_accept) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_accept && w_ptr_end) begin
                    w_state_nxt = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (w_accept) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs. Kept combinational so that reset_n
    // releases the core freeze without waiting for a clock.
    // ------------------------------------------------------------------
    always_comb begin
        busy  = 1'b0;
        stall = 1'b0;
        case (r_state)
            ST_SETTLE, ST_HDR, ST_DATA, ST_CSUM: begin
                busy  = 1'b1;
                stall = 1'b1;
            end
            default: begin
                busy  = 1'b0;
                stall = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: pointer, checksum and the registered stream byte.
    // The byte for the next beat is fetched on the edge that accepts the
    // current beat, so register data is sampled one beat ahead of its
    // appearance on tx_data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr      <= 4'd0;
            r_csum     <= 8'd0;
            r_tx_data  <= 8'd0;
            r_tx_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx_valid <= 1'b0;
                    if (start) begin
                        r_ptr  <= 4'd0;
                        r_csum <= 8'd0;
                    end
                end
                ST_SETTLE: begin
                    r_tx_data  <= HEADER;
                    r_tx_valid <= 1'b1;
                end
                ST_HDR: begin
                    // ptr is 0 here, so rd_data is r0.
                    if (w_accept) begin
                        r_tx_data <= rd_data;
                        r_csum    <= r_csum + rd_data;
                        r_ptr     <= 4'd1;
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        if (!w_ptr_end) begin
                            r_tx_data <= rd_data;
                            r_csum    <= r_csum + rd_data;
                            r_ptr     <= r_ptr + 4'd1;
                        end else begin
                            r_tx_data <= r_csum;
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_accept) begin
                        r_tx_valid <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                default: begin
                    r_tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Purpose : self-checking bench for regfile_dump (vector table, hand sequences, random frames).
// Latency : frames are observed cycle by cycle from the start edge to the done pulse.
// Backpr. : tx_ready is driven from a 4-cycle pattern per frame; stalled beats must hold.

module tb_regfile_dump;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       stall;
    logic       busy;
    logic       done;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // Behavioural register file: combinational read port.
    logic [7:0] regs [8];
    assign rd_data = regs[rd_addr];

    int errors = 0;
    int checks = 0;

    logic [7:0] got [$];

    regfile_dump #(.HEADER(8'hA5)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference checksum: plain sum of the eight register bytes, wrapped to 8 bits.
    function automatic logic [7:0] model_csum();
        int s = 0;
        for (int i = 0; i < 8; i++) s += int'(regs[i]);
        return 8'(s % 256);
    endfunction

    task automatic load_regs(input logic [63:0] v);
        for (int i = 0; i < 8; i++) regs[i] = v[8*i +: 8];
    endtask

    // Runs one frame and checks it. extra_c: cycle in which to pulse start
    // again (0 = none). chain: raise start in the done cycle and return there.
    task automatic run_frame(input string tag, input logic [7:0] exp_csum, input logic [3:0] pat,
                             input bit do_start, input int extra_c, input bit chain);
        logic [7:0] exp_b [10];
        int         n_done;
        int         done_c;
        bit         prev_hold;
        logic [7:0] prev_data;
        exp_b[0] = 8'hA5;
        for (int i = 0; i < 8; i++) exp_b[i+1] = regs[i];
        exp_b[9] = exp_csum;
        got.delete();
        n_done    = 0;
        done_c    = 0;
        prev_hold = 1'b0;
        prev_data = 8'h00;
        if (do_start) begin
            @(negedge clk);
            start = 1'b1;
        end
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start    = (c == extra_c);
            tx_ready = pat[2'(c-1)];
            chk({tag, " stall_eq_busy"}, 32'(stall), 32'(busy));
            if (c == 1) begin
                chk({tag, " settle_stall"}, 32'(stall), 32'd1);
                chk({tag, " settle_valid"}, 32'(tx_valid), 32'd0);
            end
            if (prev_hold) begin
                chk({tag, " hold_valid"}, 32'(tx_valid), 32'd1);
                chk({tag, " hold_data"}, 32'(tx_data), 32'(prev_data));
            end
            if (pat == 4'hF) begin
                chk({tag, " stall_window"}, 32'(stall), 32'(c <= 11));
                if (c >= 2 && c <= 11) chk({tag, " valid_cont"}, 32'(tx_valid), 32'd1);
            end
            if (done) begin
                n_done++;
                done_c = c;
            end
            if (tx_valid && tx_ready) got.push_back(tx_data);
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
            if (done) begin
                if (chain) start = 1'b1;
                break;
            end
        end
        chk({tag, " done_count"}, 32'(n_done), 32'd1);
        if (pat == 4'hF) chk({tag, " done_cycle"}, 32'(done_c), 32'd12);
        chk({tag, " beat_count"}, 32'(got.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < got.size()) chk($sformatf("%s byte%0d", tag, i), 32'(got[i]), 32'(exp_b[i]));
        end
        if (!chain) begin
            @(negedge clk);
            start = 1'b0;
            chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
            chk({tag, " idle_after"}, 32'(busy), 32'd0);
        end
    endtask

    typedef struct {
        logic [63:0] rv;
        logic [3:0]  pat;
        logic [7:0]  csum;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{64'h0807060504030201, 4'b1111, 8'h24};
        vecs[1] = '{64'hFFFFFFFFFFFFFFFF, 4'b1111, 8'hF8};
        vecs[2] = '{64'h0807060504030201, 4'b1001, 8'h24};
        vecs[3] = '{64'h0000000000000000, 4'b1111, 8'h00};
        vecs[4] = '{64'h1020304050607080, 4'b0101, 8'h40};

        reset_n  = 1'b0;
        start    = 1'b0;
        tx_ready = 1'b0;
        load_regs(64'h0);
        #12;
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst tx_valid", 32'(tx_valid), 32'd0);
        chk("rst tx_data", 32'(tx_data), 32'd0);
        chk("rst rd_addr", 32'(rd_addr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            load_regs(vecs[v].rv);
            run_frame($sformatf("vec%0d", v), vecs[v].csum, vecs[v].pat, 1'b1, 0, 1'b0);
        end

        // start pulsed during DATA is ignored and not queued
        load_regs(64'h0807060504030201);
        run_frame("mid_start", 8'h24, 4'hF, 1'b1, 5, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_start no_requeue", 32'(busy), 32'd0);
        end

        // start in the done cycle chains a second frame
        run_frame("chain_a", 8'h24, 4'hF, 1'b1, 0, 1'b1);
        run_frame("chain_b", 8'h24, 4'hF, 1'b0, 0, 1'b0);

        // r3 updated while not stalled is reflected in the next frame
        @(negedge clk);
        chk("r3 pre stall", 32'(stall), 32'd0);
        regs[3] = 8'h7E;
        run_frame("r3_change", 8'h9E, 4'hF, 1'b1, 0, 1'b0);

        // reset mid-frame after the third accepted beat
        load_regs(64'h0807060504030201);
        @(negedge clk);
        start    = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort pre stall", 32'(stall), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort stall", 32'(stall), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort tx_valid", 32'(tx_valid), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort tx_data", 32'(tx_data), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort no_done", 32'(done), 32'd0);
            chk("abort no_beat", 32'(tx_valid), 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        run_frame("after_abort", 8'h24, 4'hF, 1'b1, 0, 1'b0);

        // randomized frames against the reference checksum
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
            run_frame($sformatf("rand%0d", r), model_csum(), 4'($urandom_range(1, 15)), 1'b1, 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
